// File: rtl/seq_detect_param_if.sv
// Serial-bit detector bus: strobed input bit, optional pattern programming,
// and the detector's match/count/state outputs.
// Strobe semantics: bit_in is consumed on a rising clock edge only when
// bit_valid is high; there is no back-pressure, the detector accepts every
// strobed bit, and match is valid in the same cycle as the strobe.
interface seq_detect_param_if #(
  parameter int SEQ_LEN = 5,
  parameter int CNT_W   = 8
);
  localparam int STATE_W = $clog2(SEQ_LEN);

  logic               bit_valid;
  logic               bit_in;
  logic               cfg_load;
  logic [SEQ_LEN-1:0] cfg_seq;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic [STATE_W-1:0] present_state;

  modport master (
    output bit_valid, bit_in, cfg_load, cfg_seq,
    input  match, match_count, present_state
  );

  modport slave (
    input  bit_valid, bit_in, cfg_load, cfg_seq,
    output match, match_count, present_state
  );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial sequence detector with saturating match counter.
// State = length of the pattern prefix matched so far (0..SEQ_LEN-1).
// Optional feature macro: SEQ_DETECT_PROG_EN (runtime-loadable pattern via
// cfg_load/cfg_seq). Without it the pattern is the constant SEQUENCE and the
// transition logic folds to constants.
module seq_detect_param #(
  parameter int                 SEQ_LEN  = 5,
  parameter logic [SEQ_LEN-1:0] SEQUENCE = 5'b11011,
  parameter int                 OVERLAP  = 1,
  parameter int                 CNT_W    = 8
) (
  input logic                clk_100M,
  input logic                clear,
  seq_detect_param_if.slave  bus
);
  localparam int                 STATE_W    = $clog2(SEQ_LEN);
  localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(SEQ_LEN - 1);

  logic [STATE_W-1:0] state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SEQ_LEN-1:0] pattern;
  logic               load_blk;
  logic               hit;
  logic [STATE_W-1:0] nxt_state;

`ifdef SEQ_DETECT_PROG_EN
  logic [SEQ_LEN-1:0] pat_q;
  assign pattern  = pat_q;
  assign load_blk = bus.cfg_load;
`else
  logic unused_cfg;
  assign pattern    = SEQUENCE;
  assign load_blk   = 1'b0;
  assign unused_cfg = ^{bus.cfg_load, bus.cfg_seq};
`endif

  // Bit of the pattern at arrival position pos (0 = first bit received = MSB).
  function automatic logic pat_bit(input logic [SEQ_LEN-1:0] pat, input int pos);
    logic [SEQ_LEN-1:0] sh;
    sh = pat >> (SEQ_LEN - 1 - pos);
    return sh[0];
  endfunction

  // Longest suffix of (prefix_k, b) that is a proper pattern prefix. When k is
  // the last state and b completes the pattern, this is the pattern's border.
  function automatic logic [STATE_W-1:0] next_state_f(
    input logic [SEQ_LEN-1:0] pat,
    input logic [STATE_W-1:0] k,
    input logic               b
  );
    logic [STATE_W-1:0] best;
    logic               ok;
    int                 k_i;
    best = '0;
    k_i  = int'(k);
    for (int j = 1; j < SEQ_LEN; j++) begin
      if (j <= k_i + 1) begin
        ok = (b == pat_bit(pat, j - 1));
        for (int i = 0; i < SEQ_LEN - 1; i++) begin
          if (i < j - 1) begin
            if (pat_bit(pat, k_i - j + 1 + i) != pat_bit(pat, i)) ok = 1'b0;
          end
        end
        if (ok) best = STATE_W'(j);
      end
    end
    return best;
  endfunction

  // Mealy match detect and next-state selection.
  always_comb begin
    hit       = 1'b0;
    nxt_state = next_state_f(pattern, state_q, bus.bit_in);
    if (!clear && !load_blk && bus.bit_valid &&
        (state_q == LAST_STATE) && (bus.bit_in == pattern[0])) begin
      hit = 1'b1;
    end
    if (hit && (OVERLAP == 0)) nxt_state = '0;
  end

  // State, counter and pattern register; clear > cfg_load > bit_valid.
  always_ff @(posedge clk_100M) begin
    if (clear) begin
      state_q <= '0;
      cnt_q   <= '0;
`ifdef SEQ_DETECT_PROG_EN
      pat_q   <= SEQUENCE;
`endif
    end
`ifdef SEQ_DETECT_PROG_EN
    else if (bus.cfg_load) begin
      pat_q   <= bus.cfg_seq;
      state_q <= '0;
    end
`endif
    else if (bus.bit_valid) begin
      state_q <= nxt_state;
      if (hit && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.match         = hit;
  assign bus.match_count   = cnt_q;
  assign bus.present_state = state_q;
endmodule
